// File: rtl/sifh_pkg.sv
// sifh_pkg: shared defaults, invalid code and state encoding for the SiFH front end.
package sifh_pkg;
    localparam int DEF_NP        = 12;
    localparam int DEF_PIXEL_NUM = 200;
    localparam int DEF_DATA_NUM  = 2;
    localparam int DEF_ACQ_NUM   = 33333;

    localparam logic [DEF_NP-1:0] INVALID = {DEF_NP{1'b1}};

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] EMIT    = 1'b1;

    function automatic int clog2w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tdc_slot_buffer.sv
// tdc_slot_buffer: per-pixel timestamp slots with fill counters and a registered read port.
module tdc_slot_buffer
    import sifh_pkg::*;
#(
    parameter int NP        = DEF_NP,
    parameter int PIXEL_NUM = DEF_PIXEL_NUM,
    parameter int DATA_NUM  = DEF_DATA_NUM,
    localparam int PW = clog2w(PIXEL_NUM),
    localparam int SW = clog2w(DATA_NUM)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          wr_req,
    input  logic [7:0]    wr_pixel,
    input  logic [NP-1:0] wr_time,
    output logic          wr_ok,
    input  logic          rd_en,
    input  logic [PW-1:0] rd_pixel,
    input  logic [SW-1:0] rd_slot,
    output logic [NP-1:0] rd_data,
    input  logic          clear_all
);
    localparam int CW = clog2w(DATA_NUM + 1);
    localparam logic [NP-1:0] INV = {NP{1'b1}};

    logic [NP-1:0] mem [PIXEL_NUM][DATA_NUM];
    logic [CW-1:0] cnt [PIXEL_NUM];
    logic [PW-1:0] wp;

    assign wp    = PW'(wr_pixel);
    assign wr_ok = int'(wr_pixel) < PIXEL_NUM && cnt[wp] < CW'(DATA_NUM);

    always_ff @(posedge clk)
        if (wr_req && wr_ok) mem[wp][SW'(cnt[wp])] <= wr_time;

    always_ff @(posedge clk) begin
        if (!res) begin
            for (int i = 0; i < PIXEL_NUM; i++) cnt[i] <= '0;
            rd_data <= INV;
        end else begin
            if (clear_all) for (int i = 0; i < PIXEL_NUM; i++) cnt[i] <= '0;
            else if (wr_req && wr_ok) cnt[wp] <= cnt[wp] + 1'b1;
            // unfilled slots read back as the invalid code so the builder skips them
            rd_data <= rd_en && CW'(rd_slot) < cnt[rd_pixel] ? mem[rd_pixel][rd_slot] : INV;
        end
    end
endmodule

// File: rtl/tdc_event_sequencer.sv
// tdc_event_sequencer: gathers unordered TDC events per acquisition and replays them
// as the fixed pixel/slot serial stream consumed by the histogram builder.
module tdc_event_sequencer
    import sifh_pkg::*;
#(
    parameter int NP        = DEF_NP,
    parameter int PIXEL_NUM = DEF_PIXEL_NUM,
    parameter int DATA_NUM  = DEF_DATA_NUM,
    parameter int ACQ_NUM   = DEF_ACQ_NUM
) (
    input  logic          clk,
    input  logic          res,
    input  logic          tdc_valid,
    output logic          tdc_ready,
    input  logic [7:0]    tdc_pixel,
    input  logic [NP-1:0] tdc_time,
    input  logic          acq_end,
    output logic          wrEn,
    output logic [NP-1:0] data,
    output logic [19:0]   acq_idx,
    output logic          frame_done,
    output logic [15:0]   drop_cnt,
    output logic          err_overrun
);
    localparam int PW = clog2w(PIXEL_NUM);
    localparam int SW = clog2w(DATA_NUM);
    localparam logic [NP-1:0] INV = {NP{1'b1}};

    logic [0:0]    state;
    logic [PW-1:0] p;
    logic [SW-1:0] s;
    logic          drained;
    logic          accept;
    logic          wr_ok;
    logic          rd_en;
    logic          clear_all;
    logic [NP-1:0] clamped;
    logic          last_acq;

    assign tdc_ready = state == COLLECT;
    assign accept    = tdc_valid && tdc_ready;
    assign rd_en     = state == EMIT && !drained;
    assign clear_all = state == EMIT && drained;
    assign clamped   = tdc_time == INV ? INV - 1'b1 : tdc_time;
    assign last_acq  = acq_idx == 20'(ACQ_NUM - 1);

    tdc_slot_buffer #(.NP(NP), .PIXEL_NUM(PIXEL_NUM), .DATA_NUM(DATA_NUM)) u_buf (
        .clk(clk),
        .res(res),
        .wr_req(accept),
        .wr_pixel(tdc_pixel),
        .wr_time(clamped),
        .wr_ok(wr_ok),
        .rd_en(rd_en),
        .rd_pixel(p),
        .rd_slot(s),
        .rd_data(data),
        .clear_all(clear_all)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            state       <= COLLECT;
            p           <= '0;
            s           <= '0;
            drained     <= 1'b0;
            wrEn        <= 1'b0;
            acq_idx     <= '0;
            frame_done  <= 1'b0;
            drop_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            wrEn       <= rd_en;
            frame_done <= 1'b0;
            if (accept && !wr_ok && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            if (acq_end && state != COLLECT) err_overrun <= 1'b1;
            if (state == COLLECT) begin
                if (acq_end) state <= EMIT;
            end else if (!drained) begin
                s <= s == SW'(DATA_NUM - 1) ? '0 : s + 1'b1;
                if (s == SW'(DATA_NUM - 1)) begin
                    if (p == PW'(PIXEL_NUM - 1)) drained <= 1'b1;
                    else p <= p + 1'b1;
                end
            end else begin
                // one extra cycle after the last read lets the final word and the frame pulse line up
                state      <= COLLECT;
                drained    <= 1'b0;
                p          <= '0;
                frame_done <= last_acq;
                acq_idx    <= last_acq ? '0 : acq_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tdc_event_sequencer.sv
// tb_tdc_event_sequencer: timeline model of the sequencer checked every cycle,
// plus directed scenarios with hand-computed expectations and a random phase.
module tb_tdc_event_sequencer;
    localparam int NPX = 3;
    localparam int NDS = 2;
    localparam int NAQ = 2;
    localparam int NW  = NPX * NDS;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        tdc_valid = 1'b0;
    logic        tdc_ready;
    logic [7:0]  tdc_pixel = '0;
    logic [11:0] tdc_time = '0;
    logic        acq_end = 1'b0;
    logic        wrEn;
    logic [11:0] data;
    logic [19:0] acq_idx;
    logic        frame_done;
    logic [15:0] drop_cnt;
    logic        err_overrun;

    tdc_event_sequencer #(.NP(12), .PIXEL_NUM(NPX), .DATA_NUM(NDS), .ACQ_NUM(NAQ)) dut (
        .clk(clk),
        .res(res),
        .tdc_valid(tdc_valid),
        .tdc_ready(tdc_ready),
        .tdc_pixel(tdc_pixel),
        .tdc_time(tdc_time),
        .acq_end(acq_end),
        .wrEn(wrEn),
        .data(data),
        .acq_idx(acq_idx),
        .frame_done(frame_done),
        .drop_cnt(drop_cnt),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model state: cycle index = number of rising edges so far
    int cyc = 0;
    int ready_from = 0;
    int done_at = -1;
    int frame_cyc = -1;
    int m_acq = 0;
    int m_drop = 0;
    bit m_err = 0;
    int fill [NPX];
    logic [11:0] slots [NPX][NDS];
    logic [11:0] exp_data [int];

    bit chk_en = 0;
    logic [11:0] cap [$];
    int wr_total = 0;
    int frame_cnt = 0;
    int wr_at_frame = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input bit v, input int px, input logic [11:0] t, input bit ae);
        bit rdy;
        int k;
        cyc++;
        if (!res) begin
            ready_from = cyc;
            done_at = -1;
            frame_cyc = -1;
            m_acq = 0;
            m_drop = 0;
            m_err = 0;
            exp_data.delete();
            for (int i = 0; i < NPX; i++) fill[i] = 0;
            return;
        end
        rdy = (cyc - 1) >= ready_from;
        if (v && rdy) begin
            if (px < NPX && fill[px] < NDS) begin
                slots[px][fill[px]] = (t == 12'hFFF) ? 12'hFFE : t;
                fill[px]++;
            end else if (m_drop < 16'hFFFF) m_drop++;
        end
        if (ae) begin
            if (rdy) begin
                k = 0;
                for (int p = 0; p < NPX; p++)
                    for (int s = 0; s < NDS; s++) begin
                        exp_data[cyc + 1 + k] = (s < fill[p]) ? slots[p][s] : 12'hFFF;
                        k++;
                    end
                ready_from = cyc + NW + 1;
                done_at = cyc + NW + 1;
                for (int i = 0; i < NPX; i++) fill[i] = 0;
            end else m_err = 1;
        end
        if (cyc == done_at) begin
            if (m_acq == NAQ - 1) begin
                m_acq = 0;
                frame_cyc = cyc;
            end else m_acq++;
        end
    endtask

    task automatic step(input bit v, input int px, input logic [11:0] t, input bit ae);
        tdc_valid = v;
        tdc_pixel = 8'(px);
        tdc_time = t;
        acq_end = ae;
        @(posedge clk);
        model_edge(v, px, t, ae);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 12'h0, 0);
    endtask

    task automatic do_reset();
        res = 1'b0;
        step(0, 0, 12'h0, 0);
        res = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wrEn", 32'(wrEn), 32'(exp_data.exists(cyc)));
            chk("data", 32'(data), exp_data.exists(cyc) ? 32'(exp_data[cyc]) : 32'hFFF);
            chk("tdc_ready", 32'(tdc_ready), 32'(cyc >= ready_from));
            chk("acq_idx", 32'(acq_idx), 32'(m_acq));
            chk("frame_done", 32'(frame_done), 32'(cyc == frame_cyc));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("err_overrun", 32'(err_overrun), 32'(m_err));
            if (wrEn) begin
                cap.push_back(data);
                wr_total++;
            end
            if (frame_done) begin
                frame_cnt++;
                wr_at_frame = wr_total;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lo;
        logic [11:0] exp1 [NW];
        exp1 = '{12'd100, 12'd50, 12'hFFF, 12'hFFF, 12'd7, 12'hFFF};
        do_reset();
        chk_en = 1;
        chk("reset_ready", 32'(tdc_ready), 32'd1);
        chk("reset_wrEn", 32'(wrEn), 32'd0);
        chk("reset_data", 32'(data), 32'hFFF);

        // 1: basic ordering and invalid fill
        step(1, 0, 12'd100, 0);
        step(1, 2, 12'd7, 0);
        step(1, 0, 12'd50, 0);
        cap.delete();
        step(0, 0, 12'h0, 1);
        idle(8);
        chk("t1_words", 32'(cap.size()), 32'(NW));
        for (int i = 0; i < NW && i < cap.size(); i++) chk("t1_data", 32'(cap[i]), 32'(exp1[i]));

        // 2: third event to a full pixel is dropped
        step(1, 1, 12'd10, 0);
        step(1, 1, 12'd20, 0);
        step(1, 1, 12'd30, 0);
        cap.delete();
        step(0, 0, 12'h0, 1);
        idle(8);
        chk("t2_p1s0", 32'(cap[2]), 32'd10);
        chk("t2_p1s1", 32'(cap[3]), 32'd20);
        chk("t2_drop", 32'(drop_cnt), 32'd1);

        // 3: clamp and out-of-range pixel
        step(1, 0, 12'hFFF, 0);
        step(1, 5, 12'd3, 0);
        cap.delete();
        step(0, 0, 12'h0, 1);
        idle(8);
        chk("t3_clamp", 32'(cap[0]), 32'hFFE);
        chk("t3_drop", 32'(drop_cnt), 32'd2);

        // 4: event coincident with acq_end, busy window length
        cap.delete();
        step(1, 1, 12'd33, 1);
        lo = tdc_ready ? 0 : 1;
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 12'h0, 0);
            if (!tdc_ready) lo++;
        end
        chk("t4_same_cycle", 32'(cap[2]), 32'd33);
        chk("t4_busy_cycles", 32'(lo), 32'd7);

        // 5: two acquisitions form one frame
        do_reset();
        frame_cnt = 0;
        wr_total = 0;
        step(1, 0, 12'd1, 0);
        step(0, 0, 12'h0, 1);
        idle(8);
        chk("t5_acq1", 32'(acq_idx), 32'd1);
        step(1, 2, 12'd2, 0);
        step(0, 0, 12'h0, 1);
        idle(8);
        chk("t5_acq0", 32'(acq_idx), 32'd0);
        chk("t5_frames", 32'(frame_cnt), 32'd1);
        chk("t5_frame_pos", 32'(wr_at_frame), 32'd12);

        // 6: overrun during emission, then reset mid-emission
        step(1, 0, 12'd9, 0);
        cap.delete();
        step(0, 0, 12'h0, 1);
        idle(2);
        step(0, 0, 12'h0, 1);
        idle(8);
        chk("t6_err", 32'(err_overrun), 32'd1);
        chk("t6_words", 32'(cap.size()), 32'(NW));
        chk("t6_first", 32'(cap[0]), 32'd9);
        step(1, 2, 12'd44, 0);
        step(0, 0, 12'h0, 1);
        idle(3);
        do_reset();
        chk("t6_rst_wrEn", 32'(wrEn), 32'd0);
        chk("t6_rst_ready", 32'(tdc_ready), 32'd1);
        step(1, 1, 12'd66, 0);
        cap.delete();
        step(0, 0, 12'h0, 1);
        idle(8);
        chk("t6_p0", 32'(cap[0]), 32'hFFF);
        chk("t6_p1", 32'(cap[2]), 32'd66);
        chk("t6_p2", 32'(cap[4]), 32'hFFF);

        // random traffic against the timeline model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 200) == 0) res = 1'b0;
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                 ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom), $urandom_range(0, 11) == 0);
            res = 1'b1;
        end
        idle(10);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
